// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: request/grant bundle for both DM masters plus the DM-side bus
interface dm_arbiter_if #(parameter int AW = 5);
  logic          p0_req, p0_we, p0_gnt, p0_ack;
  logic [31:0]   p0_addr, p0_wd, p0_rd;
  logic          p1_req, p1_we, p1_gnt, p1_ack;
  logic [31:0]   p1_addr, p1_wd, p1_rd;
  logic [AW-1:0] dm_a;
  logic [31:0]   dm_wd, dm_rd;
  logic          dm_we;
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wd, p1_req, p1_we, p1_addr, p1_wd, dm_rd,
    output p0_gnt, p0_ack, p0_rd, p1_gnt, p1_ack, p1_rd, dm_a, dm_wd, dm_we
  );
  modport master (
    output p0_req, p0_we, p0_addr, p0_wd, p1_req, p1_we, p1_addr, p1_wd, dm_rd,
    input  p0_gnt, p0_ack, p0_rd, p1_gnt, p1_ack, p1_rd, dm_a, dm_wd, dm_we
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares single-port DM between CPU (port 0) and loader (port 1) with bounded hold.
// DM_ARB_ROUND_ROBIN_EN selects round-robin IDLE tie-break; fixed priority to port 0 otherwise.
module dm_arbiter #(
  parameter int AW       = 5,
  parameter int MAX_HOLD = 8
) (
  input logic         CLK,
  input logic         RST,
  dm_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;
  state_e     state_q, state_d, other, tie;
  logic [7:0] hold_q, hold_d;
  logic       own1, cur_req, oth_req, enter, g0, g1, unused_bits;
`ifdef DM_ARB_ROUND_ROBIN_EN
  logic       last_q, last_d;
`endif
  assign unused_bits = ^{bus.p0_addr[31:AW+2], bus.p0_addr[1:0], bus.p1_addr[31:AW+2], bus.p1_addr[1:0]};
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      hold_q  <= '0;
`ifdef DM_ARB_ROUND_ROBIN_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
`ifdef DM_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end
  always_comb begin
    own1    = state_q == OWN1;
    cur_req = own1 ? bus.p1_req : bus.p0_req;
    oth_req = own1 ? bus.p0_req : bus.p1_req;
    other   = own1 ? OWN0 : OWN1;
`ifdef DM_ARB_ROUND_ROBIN_EN
    tie     = last_q ? OWN0 : OWN1;
`else
    tie     = OWN0;
`endif
    state_d = state_q;
    if (state_q == IDLE)
      state_d = (bus.p0_req && bus.p1_req) ? tie : bus.p0_req ? OWN0 : bus.p1_req ? OWN1 : IDLE;
    else if (!cur_req || (hold_q == 8'(MAX_HOLD - 1) && oth_req))
      state_d = oth_req ? other : IDLE;
    enter  = state_d != state_q && state_d != IDLE;
    // counter only matters while the other port competes; it saturates otherwise
    hold_d = enter ? 8'd0 :
             (state_q != IDLE && cur_req && hold_q != 8'(MAX_HOLD)) ? hold_q + 8'd1 : hold_q;
`ifdef DM_ARB_ROUND_ROBIN_EN
    last_d = enter ? (state_d == OWN1) : last_q;
`endif
  end
  always_comb begin
    g0         = state_q == OWN0;
    g1         = state_q == OWN1;
    bus.p0_gnt = g0;
    bus.p1_gnt = g1;
    bus.p0_ack = g0 && bus.p0_req;
    bus.p1_ack = g1 && bus.p1_req;
    bus.p0_rd  = (g0 && bus.p0_req) ? bus.dm_rd : '0;
    bus.p1_rd  = (g1 && bus.p1_req) ? bus.dm_rd : '0;
    bus.dm_a   = g0 ? bus.p0_addr[AW+1:2] : g1 ? bus.p1_addr[AW+1:2] : '0;
    bus.dm_wd  = g0 ? bus.p0_wd : g1 ? bus.p1_wd : '0;
    bus.dm_we  = RST && (g0 ? bus.p0_req && bus.p0_we : g1 ? bus.p1_req && bus.p1_we : 1'b0);
  end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Two-port arbiter that shares the single-port 32-word data memory (DM) between the CPU memory-access stage (port 0) and a debug/loader master (port 1).
Grants exclusive DM ownership with a registered req/gnt handshake and a per-owner hold counter, so neither master starves the other.
Drives DM address, write data and write enable, and returns DM read data to the current owner.
Sits between the MA stage, the loader, and DM.

Parameters:
AW, 5, DM word-address width (2^AW words); word address = byte address bits [AW+1:2]
MAX_HOLD, 8, maximum consecutive transfers by one owner while the other port is requesting (range 1..255)

Ports:
CLK  in  1  clock, all state changes on rising edge
RST  in  1  synchronous reset, active-low
p0_req  in  1  port 0 (CPU) transfer request
p0_we  in  1  port 0 write (1) / read (0)
p0_addr  in  32  port 0 byte address
p0_wd  in  32  port 0 write data
p0_gnt  out  1  port 0 owns DM (registered)
p0_ack  out  1  port 0 transfer performed this cycle
p0_rd  out  32  port 0 read data, valid when p0_ack && !p0_we
p1_req / p1_we / p1_addr / p1_wd  in  1/1/32/32  port 1 (loader), same meaning as port 0
p1_gnt / p1_ack / p1_rd  out  1/1/32  port 1, same meaning as port 0
dm_a  out  AW  DM word address
dm_wd  out  32  DM write data
dm_we  out  1  DM write enable (DM writes on rising edge)
dm_rd  in  32  DM read data (combinational from dm_a)

Behaviour:
- States: IDLE, OWN0, OWN1. gnt0 = (state==OWN0) and gnt1 = (state==OWN1), taken straight from the state register.
- Reset: when RST==0 at an edge, go to IDLE and clear hold_cnt.
  - dm_we is also forced to 0 combinationally while RST==0, so no write happens in the reset cycle.
- Reset values: p*_gnt=0, p*_ack=0, p*_rd=0, dm_we=0, dm_a=0, dm_wd=0.
- IDLE:
  - No transfer. dm_a, dm_wd and dm_we are 0.
  - If any req is high, go to OWN0 or OWN1 at the next edge, chosen by the arbitration policy (see Optional Feature).
  - Grant latency is 1 cycle after req first rises.
- OWNx:
  - dm_a = px_addr[AW+1:2]; dm_wd = px_wd; dm_we = px_req & px_we.
  - px_ack = px_req (same cycle).
  - px_rd = dm_rd when px_ack, else 0.
  - Other-port outputs: ack=0, rd=0.
- Address rules: addr[1:0] and bits above AW+1 are ignored. Addresses wrap modulo 2^AW words. No error is flagged.
- Hold counter (8-bit):
  - Cleared on entry to any OWN state.
  - Increments on each acked transfer, saturating at MAX_HOLD.
- Release from OWNx, evaluated at each edge:
  - (a) px_req==0: go to OWNy if py_req, else IDLE.
  - (b) hold_cnt==MAX_HOLD-1, transfer this cycle, and py_req: forced handoff to OWNy. The current transfer still completes.
  - Otherwise stay in OWNx.
- Handoff takes zero idle cycles: the new owner's first transfer is in the cycle right after the edge.
- Nobody else requesting: an owner may hold DM indefinitely; the counter saturates with no effect.
- Requester contract:
  - Keep req high until ack is seen.
  - Addr, we and wd are sampled only in ack cycles.
  - Dropping req before gnt is legal: the grant occurs, but no ack is given and case (a) releases it.
- Simultaneous first requests from IDLE: resolved by the policy.

Optional Feature:
Macro DM_ARB_ROUND_ROBIN_EN.
- Defined: a last-owner register (reset 0 = port 0) is updated on every entry to OWN0/OWN1. IDLE with both req high grants the port that is not the last owner.
- Undefined: fixed priority, so port 0 (CPU) wins every IDLE tie. The last-owner register is not built.
- Forced handoff at MAX_HOLD applies in both builds.

Test Plan:
- Reset then p0_req=1, p0_we=1, addr 0x0000_0014, wd 0xDEADBEEF. Expected: p0_gnt rises 1 cycle later, p0_ack the same cycle, dm_a=5, dm_we=1. A following read of 0x14 returns p0_rd=0xDEADBEEF.
- Address wrap: port 1 writes 0x1234 at byte address 0x0000_0084. Expected: dm_a=1, and a read at byte 0x04 returns 0x1234.
- Contention, MAX_HOLD=8: p0 and p1 both hold req continuously from IDLE. Expected: OWN0 for exactly 8 acks, then OWN1 with no idle cycle between.
- Contention in the round-robin build: from IDLE with last owner 0, both req rise. Expected: p1_gnt wins first. In the fixed-priority build p0_gnt wins first.
- Reset mid-write: RST=0 in a cycle where port 0 owns DM with p0_we=1. Expected: dm_we=0 and DM contents unchanged; after reset, state is IDLE with all gnt/ack at 0.
- Early drop: p1_req pulses high for 1 cycle. Expected: p1_gnt for 1 cycle, no p1_ack, return to IDLE. A later p0_req is then granted normally.
